// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of issue, flush, writeback and register-file write signals around
// the scoreboard/writeback controller. The master side drives the block; the slave side is the block.
interface regfile_wb_ctrl_if;
    logic        iss_valid;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_rd_we;
    logic        iss_stall;
    logic        flush;

    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;

    logic        lsu_wb_valid;
    logic [4:0]  lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic        lsu_wb_ready;

    logic        reg_write_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [5:0]  sb_busy_cnt;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we, flush,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  iss_stall, alu_wb_ready, lsu_wb_ready,
        input  reg_write_en, rd_addr, rd_data, sb_busy_cnt
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we, flush,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output iss_stall, alu_wb_ready, lsu_wb_ready,
        output reg_write_en, rd_addr, rd_data, sb_busy_cnt
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register scoreboard with two-channel writeback arbitration and a registered
// register-file write port.
//
// Arbitration pointer:
//   state   | meaning
//   PTR_ALU | ALU wins the next contended cycle (reset value)
//   PTR_LSU | LSU wins the next contended cycle
module regfile_wb_ctrl #(
    parameter int unsigned RR_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wb_ctrl_if.slave  bus
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_LSU = 1'b1
    } ptr_e;

    ptr_e        r_ptr;
    ptr_e        w_ptr_nxt;
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;
    logic [5:0]  r_busy_cnt;
    logic [5:0]  w_busy_cnt_nxt;
    logic        r_we;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd_data;

    logic        w_alu_gnt;
    logic        w_lsu_gnt;
    logic        w_wb_fire;
    logic        w_wb_write;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_data;
    logic        w_stall;
    logic        w_issue;
    logic        w_set;

    // Grants double as readies; both are forced low while reset is asserted.
    always_comb begin
        w_alu_gnt = 1'b0;
        w_lsu_gnt = 1'b0;
        w_ptr_nxt = r_ptr;
        if (rst_n) begin
            if (bus.alu_wb_valid && bus.lsu_wb_valid) begin
                if ((RR_EN != 0) && (r_ptr == PTR_LSU)) begin
                    w_lsu_gnt = 1'b1;
                end else begin
                    w_alu_gnt = 1'b1;
                end
            end else begin
                w_alu_gnt = bus.alu_wb_valid;
                w_lsu_gnt = bus.lsu_wb_valid;
            end
        end
        if (w_alu_gnt) begin
            w_ptr_nxt = PTR_LSU;
        end else if (w_lsu_gnt) begin
            w_ptr_nxt = PTR_ALU;
        end
    end

    assign w_wb_fire  = w_alu_gnt | w_lsu_gnt;
    assign w_wb_rd    = w_lsu_gnt ? bus.lsu_wb_rd   : bus.alu_wb_rd;
    assign w_wb_data  = w_lsu_gnt ? bus.lsu_wb_data : bus.alu_wb_data;
    assign w_wb_write = w_wb_fire && (w_wb_rd != 5'd0);

    assign w_stall = bus.iss_valid &&
                     (r_busy[bus.iss_rs1] || r_busy[bus.iss_rs2] ||
                      (bus.iss_rd_we && r_busy[bus.iss_rd]) || bus.flush);
    assign w_issue = bus.iss_valid && !w_stall;
    assign w_set   = w_issue && bus.iss_rd_we && (bus.iss_rd != 5'd0);

    // Clear first so a same-edge reservation of the written register survives.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_rd_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[bus.iss_rd] = 1'b1;
        end
        if (bus.flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_busy_cnt_nxt = '0;
        for (int i = 0; i < 32; i++) begin
            w_busy_cnt_nxt = w_busy_cnt_nxt + 6'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= PTR_ALU;
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_we       <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
            r_we       <= w_wb_write;
            if (w_wb_write) begin
                r_rd_addr <= w_wb_rd;
                r_rd_data <= w_wb_data;
            end
        end
    end

    assign bus.iss_stall    = w_stall;
    assign bus.alu_wb_ready = w_alu_gnt;
    assign bus.lsu_wb_ready = w_lsu_gnt;
    assign bus.reg_write_en = r_we;
    assign bus.rd_addr      = r_rd_addr;
    assign bus.rd_data      = r_rd_data;
    assign bus.sb_busy_cnt  = r_busy_cnt;

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1: 1 = round-robin writeback arbitration; 0 = fixed ALU priority.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port iss_valid, input, 1 bit: decode stage presents an instruction.
REQ-005 The block SHALL have ports iss_rs1 and iss_rs2, input, 5 bits each: source register addresses.
REQ-006 The block SHALL have ports iss_rd (input, 5 bits) and iss_rd_we (input, 1 bit): destination register address and write intent.
REQ-007 The block SHALL have port iss_stall, output, 1 bit: issue blocked this cycle (combinational).
REQ-008 The block SHALL have port flush, input, 1 bit: discard all pending scoreboard reservations.
REQ-009 The block SHALL have ports alu_wb_valid (input, 1), alu_wb_rd (input, 5), alu_wb_data (input, 32) and alu_wb_ready (output, 1): ALU writeback channel.
REQ-010 The block SHALL have ports lsu_wb_valid (input, 1), lsu_wb_rd (input, 5), lsu_wb_data (input, 32) and lsu_wb_ready (output, 1): load-unit writeback channel.
REQ-011 The block SHALL have ports reg_write_en (output, 1), rd_addr (output, 5) and rd_data (output, 32): registered drive to the register-file write port.
REQ-012 The block SHALL have port sb_busy_cnt, output, 6 bits: number of reserved registers, 0..31.

Function
REQ-013 The block SHALL keep a 32-bit busy vector; bit 0 is never set.
REQ-014 iss_stall SHALL be 1 when iss_valid and any of these holds: busy[iss_rs1]; busy[iss_rs2]; iss_rd_we and busy[iss_rd]; flush. Otherwise iss_stall SHALL be 0.
REQ-015 An issue SHALL be accepted when iss_valid=1 and iss_stall=0; if iss_rd_we=1 and iss_rd!=0, busy[iss_rd] SHALL be set at that edge.
REQ-016 Each writeback channel SHALL complete a handshake on a cycle where valid=1 and ready=1; ready SHALL be combinational from the valid inputs and the arbitration pointer.
REQ-017 With one channel valid, that channel's ready SHALL be 1 and the other's 0; with neither valid, both readies SHALL be 0.
REQ-018 With both channels valid and RR_EN=1, the channel not granted last SHALL win; a 1-bit pointer SHALL update only on a grant.
REQ-019 With both channels valid and RR_EN=0, ALU SHALL always win.
REQ-020 A channel whose valid is 1 and ready is 0 SHALL hold its rd and data stable until granted; the block SHALL not drop or duplicate a writeback.
REQ-021 One edge after a handshake, reg_write_en SHALL be 1 and rd_addr/rd_data SHALL equal the granted rd and data, so write latency is 1 cycle.
REQ-022 A granted writeback with rd=0 SHALL produce reg_write_en=0 and SHALL change no busy bit.
REQ-023 With no handshake, reg_write_en SHALL be 0 on the next cycle, and rd_addr/rd_data SHALL hold their previous values.
REQ-024 busy[rd_addr] SHALL clear at the edge on which reg_write_en=1, when the register file captures the data; a dependent issue is therefore released the cycle after the write.
REQ-025 When a set (REQ-015) and a clear (REQ-024) target the same register at the same edge, the set SHALL win.
REQ-026 flush=1 SHALL clear all busy bits at the next edge; issue SHALL be blocked that cycle; writeback channels and the output stage SHALL be unaffected.
REQ-027 sb_busy_cnt SHALL be registered and SHALL equal the population count of the busy vector after each edge.

Reset
REQ-028 While rst_n=0, asynchronously: busy=0, sb_busy_cnt=0, reg_write_en=0, rd_addr=0, rd_data=0, pointer=ALU-next.
REQ-029 While rst_n=0, alu_wb_ready and lsu_wb_ready SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard any pending write; no reg_write_en pulse SHALL follow deassertion without a new handshake.

Verification
REQ-031 Scoreboard: issue rd=5, we=1 -> busy[5]=1 and sb_busy_cnt=1; issue with rs1=5 -> iss_stall=1; ALU writeback rd=5, data=0xDEADBEEF -> next cycle reg_write_en=1, rd_addr=5, rd_data=0xDEADBEEF; cycle after -> stall=0 and sb_busy_cnt=0.
REQ-032 Arbitration, RR_EN=1: both channels valid for 4 cycles with rd=1 and rd=2 -> grants ALU, LSU, ALU, LSU; rd_addr sequence 1, 2, 1, 2 at 1-cycle lag.
REQ-033 Fixed priority, RR_EN=0: both channels valid for 3 cycles -> lsu_wb_ready=0 throughout, LSU data held stable; LSU granted the cycle after alu_wb_valid drops.
REQ-034 x0: writeback rd=0, data=0x12345678 -> handshake completes, reg_write_en stays 0; issue with rd=0, we=1 -> sb_busy_cnt remains 0.
REQ-035 Flush: reserve rd=3, 7 and 9 (cnt=3); assert flush together with iss_valid -> iss_stall=1; next cycle cnt=0 and busy all zero.
REQ-036 Reset mid-write: handshake at cycle N, rst_n low before edge N+1 -> reg_write_en=0 and all outputs zero, including after release.
